// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential fetch into 1-cycle ROM, DEPTH-entry FIFO to decoder with redirect flush
// Ports: clk/rst_n (async active-low); imem_req_o/imem_addr_o/imem_rdata_i to ROM;
// inst_o/inst_pc_o/inst_valid_o/inst_ready_i to decoder; redirect_i/redirect_pc_i flush; count_o occupancy.
module inst_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req_o,
  output logic [PC_W-1:0]          imem_addr_o,
  input  logic [12:0]              imem_rdata_i,
  output logic [12:0]              inst_o,
  output logic [PC_W-1:0]          inst_pc_o,
  output logic                     inst_valid_o,
  input  logic                     inst_ready_i,
  input  logic                     redirect_i,
  input  logic [PC_W-1:0]          redirect_pc_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [PC_W-1:0] pc_q, pc_d, req_pc_q;
  logic            inflight_q, inflight_d;
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
  logic [12:0]     inst_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q [DEPTH];
  logic            push, pop;
  assign count_o      = wr_q - rd_q;
  assign inst_valid_o = count_o != '0;
  assign inst_o       = inst_mem_q[rd_q[AW-1:0]];
  assign inst_pc_o    = pc_mem_q[rd_q[AW-1:0]];
  assign imem_addr_o  = pc_q;
  // in-flight word holds a credit; a same-cycle pop is deliberately not counted
  assign imem_req_o   = rst_n && !redirect_i &&
                        (({1'b0, count_o} + (AW+2)'(inflight_q)) < (AW+2)'(DEPTH));
  assign push = inflight_q && !redirect_i;
  assign pop  = inst_valid_o && inst_ready_i && !redirect_i;
  always_comb begin
    pc_d       = redirect_i ? redirect_pc_i : imem_req_o ? pc_q + 1'b1 : pc_q;
    inflight_d = imem_req_o;
    wr_d       = redirect_i ? '0 : wr_q + (AW+1)'(push);
    rd_d       = redirect_i ? '0 : rd_q + (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= PC_W'(RESET_PC);
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      if (imem_req_o) req_pc_q <= pc_q;
      if (push) begin
        inst_mem_q[wr_q[AW-1:0]] <= imem_rdata_i;
        pc_mem_q[wr_q[AW-1:0]]   <= req_pc_q;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: random and directed stimulus against a queue-based reference model
module tb_inst_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, inst_valid, inst_ready = 1'b0, redirect = 1'b0;
  logic [7:0]  imem_addr, inst_pc, redirect_pc = '0;
  logic [12:0] imem_rdata = '0, inst;
  logic [2:0]  count;
  int errors = 0, checks = 0;
  typedef struct { logic [12:0] d; logic [7:0] p; } ent_t;
  ent_t q[$];
  logic [7:0] mpc = '0, ipc = '0;
  bit infl = 0;

  inst_fetch_queue #(.DEPTH(4), .PC_W(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rdata_i(imem_rdata), .inst_o(inst), .inst_pc_o(inst_pc),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .count_o(count));

  always #5 clk = ~clk;

  function automatic logic [12:0] rom(input logic [7:0] a);
    return {a[4:0], a} ^ 13'h1A5;
  endfunction

  always @(posedge clk) imem_rdata <= rom(imem_addr);

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rdy, input bit rd, input logic [7:0] rpc);
    bit er, ev;
    inst_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
    er = !rd && (q.size() + int'(infl) < 4);
    ev = q.size() != 0;
    chk("imem_req", 13'(imem_req), 13'(er));
    chk("imem_addr", 13'(imem_addr), 13'(mpc));
    chk("inst_valid", 13'(inst_valid), 13'(ev));
    chk("count", 13'(count), 13'(q.size()));
    if (ev) begin
      chk("inst", inst, q[0].d);
      chk("inst_pc", 13'(inst_pc), 13'(q[0].p));
    end
    @(posedge clk);
    if (rd) begin
      q.delete(); infl = 0; mpc = rpc;
    end else begin
      if (ev && rdy) void'(q.pop_front());
      if (infl) q.push_back('{rom(ipc), ipc});
      infl = er;
      if (er) begin ipc = mpc; mpc = mpc + 8'd1; end
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req", 13'(imem_req), 13'd0);
    chk("rst_valid", 13'(inst_valid), 13'd0);
    chk("rst_inst", inst, 13'd0);
    chk("rst_inst_pc", 13'(inst_pc), 13'd0);
    chk("rst_count", 13'(count), 13'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    // T1 streaming with ready high
    repeat (8) step(1, 0, 0);
    // T2 backpressure fills to DEPTH, then drain
    repeat (10) step(0, 0, 0);
    chk("t2_full_count", 13'(count), 13'd4);
    repeat (8) step(1, 0, 0);
    // T3 redirect mid-stream with partial occupancy
    repeat (2) step(0, 0, 0);
    step(0, 1, 8'h40);
    chk("t3_flushed_count", 13'(count), 13'd0);
    repeat (6) step(1, 0, 0);
    // T4 wrap through 0xFF
    step(1, 1, 8'hFE);
    repeat (8) step(1, 0, 0);
    // T5 near-full with steady dequeue
    repeat (3) step(0, 0, 0);
    repeat (10) step(1, 0, 0);
    // back-to-back redirects, last wins
    step(1, 1, 8'h10);
    step(1, 1, 8'h80);
    repeat (4) step(1, 0, 0);
    // random phase
    for (int i = 0; i < 400; i++)
      step($urandom_range(99) < 70, $urandom_range(99) < 5, 8'($urandom));
    // T6 asynchronous reset pulse mid-stream
    repeat (3) step(1, 0, 0);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs();
    q.delete(); infl = 0; mpc = 8'd0; ipc = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step(1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
